healthcare_alarm_monitor: RTL and testbench

HEALTHCARE_ALARM_MONITOR -- requirements
Module: healthcare_alarm_monitor

---
 rtl/healthcare_alarm_monitor.sv | 142 ++++++++++++++
 tb/tb_healthcare_alarm_monitor.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/healthcare_alarm_monitor.sv
// Per-channel persistence alarm monitor: IDLE/PENDING/ALARM/ACKED FSM per channel, optional raise-event counter.
// Latency: alarm is visible the cycle after the PERSIST-th valid abnormal sample; no backpressure, inputs always accepted.
// Optional event counter is compiled in with HEALTHCARE_EVENT_COUNT_EN; otherwise eventCount is tied to 0.
module healthcare_alarm_monitor #(
  parameter int NUM_CH  = 4,
  parameter int PERSIST = 3,
  parameter int CH_W    = 2
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              sampleValid,
  input  logic [NUM_CH-1:0] abnormalIn,
  input  logic [NUM_CH-1:0] ackIn,
  output logic [NUM_CH-1:0] alarm,
  output logic [NUM_CH-1:0] acked,
  output logic              anyAlarm,
  output logic [CH_W-1:0]   firstAlarmCh,
  output logic [7:0]        eventCount
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    ALARM   = 2'd2,
    ACKED   = 2'd3
  } chState_e;

  localparam logic [4:0] PERSIST_V = 5'(PERSIST);

  chState_e   stateQ [NUM_CH];
  chState_e   stateD [NUM_CH];
  logic [3:0] cntQ   [NUM_CH];
  logic [3:0] cntD   [NUM_CH];

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < NUM_CH; i++) begin
        stateQ[i] <= IDLE;
        cntQ[i]   <= 4'd0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        stateQ[i] <= stateD[i];
        cntQ[i]   <= cntD[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      stateD[i] = stateQ[i];
      cntD[i]   = cntQ[i];
      case (stateQ[i])
        IDLE: begin
          if (sampleValid && abnormalIn[i]) begin
            cntD[i]   = 4'd1;
            stateD[i] = (PERSIST == 1) ? ALARM : PENDING;
          end else begin
            cntD[i] = 4'd0;
          end
        end
        PENDING: begin
          if (sampleValid) begin
            if (abnormalIn[i]) begin
              // Counter stays below PERSIST here, so the increment cannot overshoot or wrap
              cntD[i] = cntQ[i] + 4'd1;
              if (({1'b0, cntQ[i]} + 5'd1) == PERSIST_V) begin
                stateD[i] = ALARM;
              end
            end else begin
              stateD[i] = IDLE;
              cntD[i]   = 4'd0;
            end
          end
        end
        ALARM: begin
          // Ack wins over a coincident sample; samples are otherwise ignored
          if (ackIn[i]) begin
            stateD[i] = ACKED;
          end
        end
        ACKED: begin
          if (sampleValid && !abnormalIn[i]) begin
            stateD[i] = IDLE;
            cntD[i]   = 4'd0;
          end
        end
        default: begin
          stateD[i] = IDLE;
          cntD[i]   = 4'd0;
        end
      endcase
    end
  end

  always_comb begin
    alarm        = '0;
    acked        = '0;
    firstAlarmCh = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      alarm[i] = (stateQ[i] == ALARM);
      acked[i] = (stateQ[i] == ACKED);
    end
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (stateQ[i] == ALARM) begin
        firstAlarmCh = CH_W'(i);
      end
    end
  end

  assign anyAlarm = |alarm;

`ifdef HEALTHCARE_EVENT_COUNT_EN
  logic [NUM_CH-1:0] raise;
  logic [4:0]        raiseCnt;
  logic [8:0]        eventSum;
  logic [7:0]        eventCntQ;

  // ACKED never returns to ALARM, so any transition into ALARM is a fresh raise
  always_comb begin
    raiseCnt = 5'd0;
    for (int i = 0; i < NUM_CH; i++) begin
      raise[i] = (stateD[i] == ALARM) && (stateQ[i] != ALARM);
      raiseCnt = raiseCnt + 5'(raise[i]);
    end
    eventSum = {1'b0, eventCntQ} + 9'(raiseCnt);
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      eventCntQ <= 8'd0;
    end else begin
      eventCntQ <= (eventSum > 9'd255) ? 8'hFF : eventSum[7:0];
    end
  end

  assign eventCount = eventCntQ;
`else
  assign eventCount = 8'd0;
`endif

endmodule

// File: tb/tb_healthcare_alarm_monitor.sv
// Bench for healthcare_alarm_monitor: directed scenarios plus randomized traffic against a history-based model.
// Event-count expectations follow HEALTHCARE_EVENT_COUNT_EN.
module tb_healthcare_alarm_monitor;

  localparam int NUM_CH  = 4;
  localparam int PERSIST = 3;
  localparam int CH_W    = 2;
`ifdef HEALTHCARE_EVENT_COUNT_EN
  localparam bit EV_EN = 1'b1;
`else
  localparam bit EV_EN = 1'b0;
`endif

  logic              clk;
  logic              rstN;
  logic              sampleValid;
  logic [NUM_CH-1:0] abnormalIn;
  logic [NUM_CH-1:0] ackIn;
  logic [NUM_CH-1:0] alarm;
  logic [NUM_CH-1:0] acked;
  logic              anyAlarm;
  logic [CH_W-1:0]   firstAlarmCh;
  logic [7:0]        eventCount;

  healthcare_alarm_monitor #(
    .NUM_CH (NUM_CH),
    .PERSIST(PERSIST),
    .CH_W   (CH_W)
  ) dut (
    .clk         (clk),
    .rstN        (rstN),
    .sampleValid (sampleValid),
    .abnormalIn  (abnormalIn),
    .ackIn       (ackIn),
    .alarm       (alarm),
    .acked       (acked),
    .anyAlarm    (anyAlarm),
    .firstAlarmCh(firstAlarmCh),
    .eventCount  (eventCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: run = consecutive valid abnormal samples since last clearing normal;
  // raised = alarm raised and not yet cleared; ackd = operator acknowledged it.
  int run    [NUM_CH];
  bit raised [NUM_CH];
  bit ackd   [NUM_CH];
  int events;

  logic              rv;
  logic [NUM_CH-1:0] rab;
  logic [NUM_CH-1:0] rak;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < NUM_CH; i++) begin
      run[i]    = 0;
      raised[i] = 1'b0;
      ackd[i]   = 1'b0;
    end
    events = 0;
  endtask

  task automatic modelStep(input logic v, input logic [NUM_CH-1:0] ab, input logic [NUM_CH-1:0] ak);
    for (int i = 0; i < NUM_CH; i++) begin
      if (ak[i] && raised[i] && !ackd[i]) begin
        ackd[i] = 1'b1;
      end else if (v) begin
        if (!ab[i]) begin
          if (!raised[i] || ackd[i]) begin
            run[i]    = 0;
            raised[i] = 1'b0;
            ackd[i]   = 1'b0;
          end
        end else if (!raised[i]) begin
          run[i]++;
          if (run[i] == PERSIST) begin
            raised[i] = 1'b1;
            if (events < 255) events++;
          end
        end
      end
    end
  endtask

  task automatic checkOutputs();
    logic [NUM_CH-1:0] expAlarm;
    logic [NUM_CH-1:0] expAcked;
    int                expFirst;
    expAlarm = '0;
    expAcked = '0;
    expFirst = -1;
    for (int i = 0; i < NUM_CH; i++) begin
      expAlarm[i] = raised[i] && !ackd[i];
      expAcked[i] = raised[i] && ackd[i];
      if (expAlarm[i] && expFirst < 0) expFirst = i;
    end
    if (expFirst < 0) expFirst = 0;
    checkEq("alarm", 32'(alarm), 32'(expAlarm));
    checkEq("acked", 32'(acked), 32'(expAcked));
    checkEq("anyAlarm", 32'(anyAlarm), 32'(|expAlarm));
    checkEq("firstAlarmCh", 32'(firstAlarmCh), 32'(expFirst));
    checkEq("eventCount", 32'(eventCount), EV_EN ? 32'(events) : 32'd0);
  endtask

  // Called at a falling edge; returns at the next falling edge with outputs checked
  task automatic doCycle(input logic v, input logic [NUM_CH-1:0] ab, input logic [NUM_CH-1:0] ak);
    sampleValid = v;
    abnormalIn  = ab;
    ackIn       = ak;
    @(posedge clk);
    modelStep(v, ab, ak);
    @(negedge clk);
    checkOutputs();
  endtask

  // Asserts reset between edges to exercise the asynchronous path
  task automatic applyReset();
    sampleValid = 1'b0;
    abnormalIn  = '0;
    ackIn       = '0;
    #2 rstN = 1'b0;
    #1;
    checkEq("rst_alarm", 32'(alarm), 32'd0);
    checkEq("rst_acked", 32'(acked), 32'd0);
    checkEq("rst_any", 32'(anyAlarm), 32'd0);
    checkEq("rst_first", 32'(firstAlarmCh), 32'd0);
    checkEq("rst_events", 32'(eventCount), 32'd0);
    modelReset();
    @(negedge clk);
    rstN = 1'b1;
  endtask

  initial begin
    rstN        = 1'b0;
    sampleValid = 1'b0;
    abnormalIn  = '0;
    ackIn       = '0;
    modelReset();
    #1;
    checkOutputs();
    @(negedge clk);
    rstN = 1'b1;

    // Persistence on ch2
    doCycle(1'b1, 4'b0100, 4'b0000);
    doCycle(1'b1, 4'b0100, 4'b0000);
    checkEq("p_alarm_before", 32'(alarm), 32'd0);
    doCycle(1'b1, 4'b0100, 4'b0000);
    checkEq("p_alarm", 32'(alarm), 32'b0100);
    checkEq("p_any", 32'(anyAlarm), 32'd1);
    checkEq("p_first", 32'(firstAlarmCh), 32'd2);
    checkEq("p_events", 32'(eventCount), EV_EN ? 32'd1 : 32'd0);

    // Interrupted run on ch0
    applyReset();
    doCycle(1'b1, 4'b0001, 4'b0000);
    doCycle(1'b1, 4'b0001, 4'b0000);
    doCycle(1'b1, 4'b0000, 4'b0000);
    doCycle(1'b1, 4'b0001, 4'b0000);
    doCycle(1'b1, 4'b0001, 4'b0000);
    checkEq("int_alarm0", 32'(alarm[0]), 32'd0);

    // Gaps between valid samples on ch1
    applyReset();
    doCycle(1'b1, 4'b0010, 4'b0000);
    doCycle(1'b1, 4'b0010, 4'b0000);
    for (int k = 0; k < 5; k++) doCycle(1'b0, 4'b0000, 4'b0000);
    checkEq("gap_alarm_before", 32'(alarm[1]), 32'd0);
    doCycle(1'b1, 4'b0010, 4'b0000);
    checkEq("gap_alarm1", 32'(alarm[1]), 32'd1);

    // Ack coinciding with a valid sample
    applyReset();
    for (int k = 0; k < 3; k++) doCycle(1'b1, 4'b1010, 4'b0000);
    checkEq("ack_pre", 32'(alarm), 32'b1010);
    doCycle(1'b1, 4'b1010, 4'b0010);
    checkEq("ack_alarm", 32'(alarm), 32'b1000);
    checkEq("ack_acked", 32'(acked), 32'b0010);
    checkEq("ack_first", 32'(firstAlarmCh), 32'd3);
    doCycle(1'b1, 4'b1010, 4'b0000);
    checkEq("ack_hold", 32'(acked), 32'b0010);
    doCycle(1'b1, 4'b0000, 4'b0000);
    checkEq("ack_clear", 32'(acked), 32'b0000);
    checkEq("ack_ch3_stays", 32'(alarm), 32'b1000);

    // Reset mid-PENDING (ch0) with ch3 still in ALARM; history must be discarded
    doCycle(1'b1, 4'b0001, 4'b0000);
    doCycle(1'b1, 4'b0001, 4'b0000);
    applyReset();
    doCycle(1'b1, 4'b0001, 4'b0000);
    doCycle(1'b1, 4'b0001, 4'b0000);
    checkEq("rst_hist", 32'(alarm), 32'd0);
    doCycle(1'b1, 4'b0001, 4'b0000);
    checkEq("rst_hist_alarm", 32'(alarm), 32'b0001);

    // 260 raise events: 65 rounds of all four channels raising together
    applyReset();
    for (int r = 0; r < 65; r++) begin
      for (int k = 0; k < 3; k++) doCycle(1'b1, 4'b1111, 4'b0000);
      doCycle(1'b0, 4'b0000, 4'b1111);
      doCycle(1'b1, 4'b0000, 4'b0000);
    end
    checkEq("sat_events", 32'(eventCount), EV_EN ? 32'd255 : 32'd0);

    // Randomized traffic with occasional asynchronous resets
    applyReset();
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(199) == 0) applyReset();
      rv = ($urandom_range(3) != 0);
      for (int b = 0; b < NUM_CH; b++) begin
        rab[b] = ($urandom_range(9) < 7);
        rak[b] = ($urandom_range(9) == 0);
      end
      doCycle(rv, rab, rak);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
